// File: rtl/seq_signed_subtractor_pkg.sv
// Shared types and helpers for the sequential signed subtractor.
// Latency: none (package only).
// Backpressure: not applicable.
package seq_sub_pkg;

  // Controller states: waiting for operands, stepping digits, holding a result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Digit counter width; at least one bit even when there is a single digit step.
  function automatic int cnt_width(input int width, input int digit);
    int n;
    n = width / digit;
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seq_signed_subtractor_if.sv
// Operand/result handshake bundle for the sequential signed subtractor.
// Latency: none (wiring only).
// Backpressure: valid/ready on both the operand side and the result side.
interface seq_signed_subtractor_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;
  logic             busy;

  // Producer of operands and consumer of results.
  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, bout, ovf, busy
  );

  // The subtractor itself.
  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, bout, ovf, busy
  );
endinterface

// File: rtl/seq_signed_subtractor_digit.sv
// Combinational DIGIT-bit ripple subtractor: diff = a - b - bin.
// Latency: zero cycles (pure combinational).
// Backpressure: none; the caller decides when the result is used.
module digit_subtractor #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             bin,
  output logic [DIGIT-1:0] diff,
  output logic             bout,
  output logic             bmsb_in
);

  logic [DIGIT:0] brw;

  // Per-bit full-subtract ripple; brw[i] is the borrow into bit i.
  always_comb begin
    brw    = '0;
    diff   = '0;
    brw[0] = bin;
    for (int i = 0; i < DIGIT; i++) begin
      diff[i]  = a[i] ^ b[i] ^ brw[i];
      brw[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & brw[i]);
    end
  end

  assign bout    = brw[DIGIT];
  assign bmsb_in = brw[DIGIT-1];

endmodule

// File: rtl/seq_signed_subtractor.sv
// Digit-serial signed subtractor: diff = a - b - bin, DIGIT bits per cycle, LSB digit first.
// Latency: WIDTH/DIGIT cycles from operand accept to out_valid; one result per N+2 cycles.
// Backpressure: in_ready only in IDLE; out_valid holds the result until out_ready.
module seq_signed_subtractor
  import seq_sub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  seq_signed_subtractor_if.slave bus
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = cnt_width(WIDTH, DIGIT);

  // Reject geometries where the digits do not tile the operand exactly.
  if ((WIDTH % DIGIT) != 0) begin : g_bad_geometry
    $error("seq_signed_subtractor: WIDTH (%0d) must be a multiple of DIGIT (%0d)", WIDTH, DIGIT);
  end

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] diff_sh;
  logic [WIDTH-1:0] a_shift;
  logic [WIDTH-1:0] b_shift;
  logic [WIDTH-1:0] diff_shift;
  logic             brw;
  logic [CW-1:0]    cnt;
  logic             bout_q;
  logic             ovf_q;
  logic [DIGIT-1:0] dig_diff;
  logic             dig_bout;
  logic             dig_bmsb;
  logic             last;

  assign last = (cnt == CW'(N - 1));

  // One digit of the borrow chain per cycle keeps the critical path to DIGIT bits.
  digit_subtractor #(
    .DIGIT (DIGIT)
  ) u_digit (
    .a       (a_sh[DIGIT-1:0]),
    .b       (b_sh[DIGIT-1:0]),
    .bin     (brw),
    .diff    (dig_diff),
    .bout    (dig_bout),
    .bmsb_in (dig_bmsb)
  );

  // Operands shift down a digit per step; results enter from the top so they end LSB-aligned.
  if (DIGIT == WIDTH) begin : g_single_digit
    assign a_shift    = '0;
    assign b_shift    = '0;
    assign diff_shift = dig_diff;
  end else begin : g_multi_digit
    assign a_shift    = {{DIGIT{1'b0}}, a_sh[WIDTH-1:DIGIT]};
    assign b_shift    = {{DIGIT{1'b0}}, b_sh[WIDTH-1:DIGIT]};
    assign diff_shift = {dig_diff, diff_sh[WIDTH-1:DIGIT]};
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: accept in IDLE, step N digits, hold until the result is taken.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.in_valid)  state_nxt = RUN;
      RUN:     if (last)          state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: load operands on accept, then one digit per RUN cycle; flags captured on the last digit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh    <= '0;
      b_sh    <= '0;
      diff_sh <= '0;
      brw     <= 1'b0;
      cnt     <= '0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      if (state == IDLE && bus.in_valid) begin
        a_sh <= bus.a;
        b_sh <= bus.b;
        brw  <= bus.bin;
        cnt  <= '0;
      end else if (state == RUN) begin
        a_sh    <= a_shift;
        b_sh    <= b_shift;
        diff_sh <= diff_shift;
        brw     <= dig_bout;
        if (last) begin
          bout_q <= dig_bout;
          ovf_q  <= dig_bout ^ dig_bmsb;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state != IDLE);
  assign bus.diff      = diff_sh;
  assign bus.bout      = bout_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_seq_signed_subtractor.sv
// Bench for seq_signed_subtractor at DIGIT = 4, 16 and 1 with WIDTH = 16.
// Latency: checks N-cycle accept-to-valid latency per instance.
// Backpressure: holds out_ready low to check result stability.
module tb_seq_signed_subtractor;

  localparam int W  = 16;
  localparam int NI = 3;

  function automatic int digit_of(input int g);
    return (g == 0) ? 4 : ((g == 1) ? 16 : 1);
  endfunction

  typedef struct {
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
  } exp_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    int           hold;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [NI-1:0]        rst_s;
  logic [NI-1:0]        in_valid_s;
  logic [NI-1:0]        bin_s;
  logic [NI-1:0]        out_ready_s;
  logic [NI-1:0][W-1:0] a_s;
  logic [NI-1:0][W-1:0] b_s;
  wire  [NI-1:0]        in_ready_w;
  wire  [NI-1:0]        out_valid_w;
  wire  [NI-1:0]        bout_w;
  wire  [NI-1:0]        ovf_w;
  wire  [NI-1:0]        busy_w;
  wire  [NI-1:0][W-1:0] diff_w;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    seq_signed_subtractor_if #(.WIDTH(W)) ifc ();
    assign ifc.in_valid  = in_valid_s[g];
    assign ifc.a         = a_s[g];
    assign ifc.b         = b_s[g];
    assign ifc.bin       = bin_s[g];
    assign ifc.out_ready = out_ready_s[g];
    assign in_ready_w[g]  = ifc.in_ready;
    assign out_valid_w[g] = ifc.out_valid;
    assign diff_w[g]      = ifc.diff;
    assign bout_w[g]      = ifc.bout;
    assign ovf_w[g]       = ifc.ovf;
    assign busy_w[g]      = ifc.busy;

    seq_signed_subtractor #(
      .WIDTH (W),
      .DIGIT (digit_of(g))
    ) u_dut (
      .clk   (clk),
      .rst_n (rst_s[g]),
      .bus   (ifc)
    );
  end

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: unsigned borrow from a wide subtract, overflow from the true signed range.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    exp_t         e;
    logic [W:0]   u;
    int           s;
    u = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
    s = int'($signed(a)) - int'($signed(b)) - int'({31'd0, bin});
    e.diff = u[W-1:0];
    e.bout = u[W];
    e.ovf  = (s > 32767) || (s < -32768);
    return e;
  endfunction

  task automatic do_op(input int idx, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic bin, input int hold);
    exp_t  e;
    int    k;
    string t;
    t = $sformatf("d%0d a=%h b=%h bin=%0d", digit_of(idx), a, b, bin);
    @(negedge clk);
    check_eq({t, " in_ready"}, 32'(in_ready_w[idx]), 32'd1);
    in_valid_s[idx] = 1'b1;
    a_s[idx]        = a;
    b_s[idx]        = b;
    bin_s[idx]      = bin;
    @(posedge clk);
    sb.push_back(model(a, b, bin));
    @(negedge clk);
    in_valid_s[idx] = 1'b0;
    a_s[idx]        = '0;
    b_s[idx]        = '0;
    bin_s[idx]      = 1'b0;
    check_eq({t, " busy"}, 32'(busy_w[idx]), 32'd1);
    k = 0;
    while (!out_valid_w[idx] && k < 64) begin
      @(posedge clk);
      k++;
      @(negedge clk);
    end
    check_eq({t, " latency"}, 32'(k), 32'(W / digit_of(idx)));
    if (sb.size() == 0) begin
      check_eq({t, " scoreboard_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check_eq({t, " diff"}, 32'(diff_w[idx]), 32'(e.diff));
      check_eq({t, " bout"}, 32'(bout_w[idx]), 32'(e.bout));
      check_eq({t, " ovf"},  32'(ovf_w[idx]),  32'(e.ovf));
      for (int h = 0; h < hold; h++) begin
        @(posedge clk);
        @(negedge clk);
        check_eq({t, " hold out_valid"}, 32'(out_valid_w[idx]), 32'd1);
        check_eq({t, " hold diff"},      32'(diff_w[idx]),      32'(e.diff));
        check_eq({t, " hold bout"},      32'(bout_w[idx]),      32'(e.bout));
        check_eq({t, " hold in_ready"},  32'(in_ready_w[idx]),  32'd0);
      end
    end
    out_ready_s[idx] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready_s[idx] = 1'b0;
    check_eq({t, " release out_valid"}, 32'(out_valid_w[idx]), 32'd0);
    check_eq({t, " release in_ready"},  32'(in_ready_w[idx]),  32'd1);
    check_eq({t, " release busy"},      32'(busy_w[idx]),      32'd0);
  endtask

  task automatic check_cleared(input int idx, input string t);
    check_eq({t, " out_valid"}, 32'(out_valid_w[idx]), 32'd0);
    check_eq({t, " busy"},      32'(busy_w[idx]),      32'd0);
    check_eq({t, " diff"},      32'(diff_w[idx]),      32'd0);
    check_eq({t, " bout"},      32'(bout_w[idx]),      32'd0);
    check_eq({t, " ovf"},       32'(ovf_w[idx]),       32'd0);
  endtask

  // Reset pulsed two edges into the operation, then a clean follow-up operation.
  task automatic reset_mid(input int idx);
    string t;
    t = $sformatf("d%0d midrst", digit_of(idx));
    @(negedge clk);
    in_valid_s[idx] = 1'b1;
    a_s[idx]        = 16'hFFFF;
    b_s[idx]        = 16'h0001;
    @(posedge clk);
    @(negedge clk);
    in_valid_s[idx] = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_s[idx] = 1'b0;
    #1;
    check_cleared(idx, t);
    @(posedge clk);
    @(negedge clk);
    rst_s[idx] = 1'b1;
    @(negedge clk);
    check_eq({t, " in_ready"}, 32'(in_ready_w[idx]), 32'd1);
    check_cleared(idx, {t, " post"});
    do_op(idx, 16'h1234, 16'h0234, 1'b0, 0);
  endtask

  vec_t vecs[5];

  initial begin
    vecs[0] = '{a: 16'h0005, b: 16'h0003, bin: 1'b0, hold: 0};
    vecs[1] = '{a: 16'h0000, b: 16'h0001, bin: 1'b0, hold: 0};
    vecs[2] = '{a: 16'h8000, b: 16'h0001, bin: 1'b0, hold: 0};
    vecs[3] = '{a: 16'h7FFF, b: 16'hFFFF, bin: 1'b0, hold: 0};
    vecs[4] = '{a: 16'h0010, b: 16'h0010, bin: 1'b1, hold: 5};

    rst_s       = '0;
    in_valid_s  = '0;
    bin_s       = '0;
    out_ready_s = '0;
    a_s         = '0;
    b_s         = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < NI; i++) check_cleared(i, $sformatf("d%0d reset", digit_of(i)));
    rst_s = '1;
    @(negedge clk);
    for (int i = 0; i < NI; i++)
      check_eq($sformatf("d%0d reset in_ready", digit_of(i)), 32'(in_ready_w[i]), 32'd1);

    for (int i = 0; i < NI; i++) begin
      for (int v = 0; v < 5; v++) do_op(i, vecs[v].a, vecs[v].b, vecs[v].bin, vecs[v].hold);
      for (int r = 0; r < 4; r++)
        do_op(i, 16'($urandom), 16'($urandom), 1'($urandom_range(1, 0)), r % 2);
      reset_mid(i);
    end

    check_eq("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
